// File: rtl/mdu_writeback_unit.sv
// mdu_writeback_unit
// Iterative 16-bit multiply/divide unit that acts as a second writer on the
// register-file write port. An operation is captured on a start pulse. The
// unit performs WIDTH shift-add (MUL/MULHU) or restoring shift-subtract
// (DIVU/REMU) steps, latches the result, and then holds RegWr until the
// writeback arbiter grants the port.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for start; operands, op and rd captured on start
// RUN   | one arithmetic step per edge; the edge after step WIDTH latches the result
// WB    | RegWr high, Rd/WBus held until wb_grant
//
// All state updates on the falling edge of clk, matching the pipeline registers.
// For a divide by zero no special case is needed. The restoring divider
// subtracts zero on every step, so the quotient fills with ones (0xFFFF) and
// the remainder shifts in the dividend unchanged (REMU returns a).

module mdu_writeback_unit #(
    parameter int WIDTH   = 16,
    parameter int REGBITS = 3
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [1:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [REGBITS-1:0] rd_in,
    input  logic               wb_grant,
    output logic               busy,
    output logic               RegWr,
    output logic [REGBITS-1:0] Rd,
    output logic [WIDTH-1:0]   WBus
);

    localparam int CW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t               state;
    state_t               state_nxt;

    logic [1:0]           op_r;
    logic [WIDTH-1:0]     a_r;
    logic [WIDTH-1:0]     b_r;
    logic [WIDTH-1:0]     mq;
    logic [REGBITS-1:0]   rd_r;
    logic [CW-1:0]        cnt;
    logic [2*WIDTH-1:0]   acc;
    logic [2*WIDTH-1:0]   acc_step;
    logic [WIDTH:0]       trial;
    logic [WIDTH:0]       diff;
    logic                 steps_done;

    assign steps_done = (cnt == CW'(WIDTH));

    // State register.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. Leaving WB always goes to IDLE, so a start on the grant edge is not taken.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (start)      state_nxt = S_RUN;
            S_RUN:   if (steps_done) state_nxt = S_WB;
            S_WB:    if (wb_grant)   state_nxt = S_IDLE;
            default:                 state_nxt = S_IDLE;
        endcase
    end

    // Outputs decoded from state.
    always_comb begin
        busy  = (state == S_RUN) || (state == S_WB);
        RegWr = (state == S_WB);
    end

    // One arithmetic step. Multiply is MSB-first shift-add over the multiplier in mq.
    // Divide shifts the dividend in from mq. It keeps the remainder in acc[hi] and builds the quotient in acc[lo].
    always_comb begin
        trial    = {acc[2*WIDTH-1:WIDTH], mq[WIDTH-1]};
        diff     = trial - {1'b0, b_r};
        acc_step = '0;
        if (op_r[1]) begin
            if (!diff[WIDTH]) begin
                acc_step = {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_step = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_step = {acc[2*WIDTH-2:0], 1'b0}
                     + (mq[WIDTH-1] ? {{WIDTH{1'b0}}, a_r} : {(2*WIDTH){1'b0}});
        end
    end

    // Datapath: capture on start, step in RUN, latch result and destination when the steps are done.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            op_r <= '0;
            a_r  <= '0;
            b_r  <= '0;
            mq   <= '0;
            rd_r <= '0;
            cnt  <= '0;
            acc  <= '0;
            Rd   <= '0;
            WBus <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        op_r <= op;
                        a_r  <= a;
                        b_r  <= b;
                        mq   <= op[1] ? a : b;
                        rd_r <= rd_in;
                        cnt  <= '0;
                        acc  <= '0;
                    end
                end
                S_RUN: begin
                    if (!steps_done) begin
                        acc <= acc_step;
                        mq  <= {mq[WIDTH-2:0], 1'b0};
                        cnt <= cnt + 1'b1;
                    end else begin
                        Rd   <= rd_r;
                        WBus <= op_r[0] ? acc[2*WIDTH-1:WIDTH] : acc[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
